// File: rtl/cpu_wishbone_bridge.sv
// cpu_wishbone_bridge: turns CPU request-unit read/write strobes into single-beat Wishbone classic cycles.
// Define CPU_WB_TIMEOUT_EN to abort a BUS cycle that sees no ack within TIMEOUT_CYCLES.
module cpu_wishbone_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_to_mem,
    input  logic        write_to_mem,
    input  logic [3:0]  sel_to_mem,
    input  logic [31:0] adr_to_mem,
    input  logic [31:0] data_to_mem,
    output logic        mem_busy,
    output logic [31:0] data_from_mem,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic        ack_i,
    input  logic [31:0] dat_i,
    output logic        bus_timeout
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_req;
    logic            w_ack;
    logic            w_timeout;
    logic            w_busy;
    logic            r_cyc;
    logic            r_we;
    logic [SW-1:0]   r_sel;
    logic [DW-1:0]   r_adr;
    logic [DW-1:0]   r_dat;
    logic [DW-1:0]   r_rdata;
    logic            w_unused;

    assign w_req = read_to_mem | write_to_mem;
    assign w_ack = (r_state == S_BUS) & ack_i;

    // Byte offset bits never reach the bus; the parameters fold in so both builds see them used.
    assign w_unused = ^{adr_to_mem[1:0], ERR_DATA, TIMEOUT_CYCLES};

`ifdef CPU_WB_TIMEOUT_EN
    localparam int unsigned CNT_W   = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;

    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_timeout;

    // Abort fires on the last allowed BUS cycle; a same-cycle ack takes priority.
    assign w_timeout = (r_state == S_BUS) & ~ack_i & (r_cnt == CNT_W'(TO_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state != S_BUS) begin
            r_cnt <= '0;
        end else if (!ack_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_timeout <= 1'b0;
        end else begin
            r_bus_timeout <= w_timeout;
        end
    end

    assign bus_timeout = r_bus_timeout;
`else
    assign w_timeout   = 1'b0;
    assign bus_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_next = S_BUS;
            S_BUS:   if (w_ack | w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Busy stalls the request unit in the same cycle a request appears; DONE releases it for one cycle.
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            S_IDLE:  w_busy = w_req & ~rst;
            S_BUS:   w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    // Request capture and read-data return; bus outputs hold the registered copy for the whole cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_cyc <= 1'b1;
                        r_we  <= write_to_mem;
                        r_sel <= sel_to_mem;
                        r_adr <= {adr_to_mem[DW-1:2], 2'b00};
                        r_dat <= data_to_mem;
                    end
                end
                S_BUS: begin
                    if (w_ack) begin
                        r_cyc <= 1'b0;
                        if (!r_we) r_rdata <= dat_i;
                    end else if (w_timeout) begin
                        r_cyc <= 1'b0;
                        if (!r_we) r_rdata <= ERR_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_busy      = w_busy;
    assign data_from_mem = r_rdata;
    assign cyc_o         = r_cyc;
    assign stb_o         = r_cyc;
    assign we_o          = r_we;
    assign sel_o         = r_sel;
    assign adr_o         = r_adr;
    assign dat_o         = r_dat;

endmodule

// File: tb/tb_cpu_wishbone_bridge.sv
// Scoreboard bench for cpu_wishbone_bridge: requests push expected bus/return values,
// a negedge monitor checks every BUS cycle and pops at each DONE.
module tb_cpu_wishbone_bridge;

`ifdef CPU_WB_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_to_mem, write_to_mem;
    logic [3:0]  sel_to_mem;
    logic [31:0] adr_to_mem, data_to_mem;
    logic        mem_busy;
    logic [31:0] data_from_mem;
    logic        cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_o;
    logic        ack_i;
    logic [31:0] dat_i;
    logic        bus_timeout;

    cpu_wishbone_bridge #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .read_to_mem(read_to_mem), .write_to_mem(write_to_mem),
        .sel_to_mem(sel_to_mem), .adr_to_mem(adr_to_mem), .data_to_mem(data_to_mem),
        .mem_busy(mem_busy), .data_from_mem(data_from_mem),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
        .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i),
        .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        int          ncyc;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          pushed = 0;
    int          popped = 0;
    logic [31:0] model_rdata = 32'h0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: per-cycle bus checks against the queue head; pop on the cycle after cyc_o falls.
    logic prev_cyc = 1'b0;
    int   ncyc     = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_cyc = 1'b0;
            ncyc     = 0;
        end else begin
            if (cyc_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: cyc_o=%b with no request queued at %0t", cyc_o, $time);
                end else begin
                    chk("stb_o_bus", 32'(stb_o), 32'(1));
                    chk("busy_bus", 32'(mem_busy), 32'(1));
                    chk("we_o", 32'(we_o), 32'(exp_q[0].we));
                    chk("sel_o", 32'(sel_o), 32'(exp_q[0].sel));
                    chk("adr_o", adr_o, exp_q[0].adr);
                    chk("dat_o", dat_o, exp_q[0].dat);
                end
                ncyc++;
            end else if (prev_cyc) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: completion with empty queue at %0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    popped++;
                    chk("bus_cycles", 32'(ncyc), 32'(e.ncyc));
                    chk("data_from_mem", data_from_mem, e.rdata);
                    chk("busy_done", 32'(mem_busy), 32'(0));
                    chk("stb_o_done", 32'(stb_o), 32'(0));
                    chk("bus_timeout_done", 32'(bus_timeout), 32'(e.to));
                end
                ncyc = 0;
            end
            prev_cyc = cyc_o;
        end
    end

    // One request; ack after 'waits' wait states, or no ack at all (timeout path) when ack_en=0.
    task automatic do_req(input logic rd, input logic wr, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat, input logic [31:0] exp_adr,
                          input logic [31:0] rdata, input int waits, input logic ack_en);
        exp_t e;
        @(posedge clk); #1;
        chk("idle_cyc", 32'(cyc_o), 32'(0));
        chk("idle_timeout", 32'(bus_timeout), 32'(0));
        read_to_mem  = rd;
        write_to_mem = wr;
        sel_to_mem   = sel;
        adr_to_mem   = adr;
        data_to_mem  = dat;
        if (!wr) model_rdata = ack_en ? rdata : ERR;
        e.we    = wr;
        e.sel   = sel;
        e.adr   = exp_adr;
        e.dat   = dat;
        e.rdata = model_rdata;
        e.ncyc  = waits + 1;
        e.to    = ~ack_en;
        exp_q.push_back(e);
        pushed++;
        #1 chk("busy_on_request", 32'(mem_busy), 32'(1));
        @(posedge clk); #1;
        // Scramble the request inputs; the bridge must keep driving its registered copy.
        read_to_mem  = wr;
        write_to_mem = rd;
        sel_to_mem   = ~sel;
        adr_to_mem   = ~adr;
        data_to_mem  = ~dat;
        dat_i        = 32'h5555_AAAA;
        repeat (waits) begin
            @(posedge clk); #1;
        end
        if (ack_en) begin
            ack_i = 1'b1;
            dat_i = rdata;
        end
        @(posedge clk); #1;
        ack_i        = 1'b0;
        dat_i        = 32'hFFFF_0000;
        chk("busy_in_done", 32'(mem_busy), 32'(0));
        read_to_mem  = 1'b0;
        write_to_mem = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, pushed=%0d popped=%0d", pushed, popped);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        read_to_mem = 1'b0; write_to_mem = 1'b0;
        sel_to_mem = 4'h0; adr_to_mem = 32'h0; data_to_mem = 32'h0;
        ack_i = 1'b0; dat_i = 32'h0;
        #3;
        chk("rst_cyc", 32'(cyc_o), 32'(0));
        chk("rst_busy", 32'(mem_busy), 32'(0));
        chk("rst_data", data_from_mem, 32'h0);
        chk("rst_timeout", 32'(bus_timeout), 32'(0));
        #9 rst = 1'b0;

        // Read, zero wait states
        do_req(1'b1, 1'b0, 4'hF, 32'h0000_1006, 32'h0, 32'h0000_1004, 32'hCAFE_F00D, 0, 1'b1);
        // Write, three wait states; read data must not change
        do_req(1'b0, 1'b1, 4'b0011, 32'h0000_2000, 32'h1234_5678, 32'h0000_2000, 32'h0BAD_0BAD, 3, 1'b1);

        // Idle cycle with a stray ack
        @(posedge clk); #1;
        ack_i = 1'b1;
        dat_i = 32'hBAD0_BAD0;
        #1;
        chk("noreq_busy", 32'(mem_busy), 32'(0));
        chk("noreq_cyc", 32'(cyc_o), 32'(0));
        @(posedge clk); #1;
        ack_i = 1'b0;
        chk("stray_ack_data", data_from_mem, model_rdata);
        chk("stray_ack_cyc", 32'(cyc_o), 32'(0));

        // Back-to-back instruction fetch / data write
        do_req(1'b1, 1'b0, 4'hF,    32'h0000_2000, 32'h0,         32'h0000_2000, 32'h1111_0001, 0, 1'b1);
        do_req(1'b0, 1'b1, 4'b1100, 32'h0000_3003, 32'hA5A5_5A5A, 32'h0000_3000, 32'h0,         1, 1'b1);
        do_req(1'b1, 1'b0, 4'hF,    32'h0000_2004, 32'h0,         32'h0000_2004, 32'h2222_0002, 2, 1'b1);
        do_req(1'b0, 1'b1, 4'b0001, 32'h0000_3008, 32'h0000_00FF, 32'h0000_3008, 32'h0,         0, 1'b1);
        // Read and write together: write wins
        do_req(1'b1, 1'b1, 4'hF,    32'h0000_4001, 32'h7777_8888, 32'h0000_4000, 32'h9999_9999, 0, 1'b1);

`ifdef CPU_WB_TIMEOUT_EN
        // Read with no ack: abort after four BUS cycles, then a normal read
        do_req(1'b1, 1'b0, 4'hF, 32'h0000_5000, 32'h0, 32'h0000_5000, 32'h0, 3, 1'b0);
        do_req(1'b1, 1'b0, 4'hF, 32'h0000_5004, 32'h0, 32'h0000_5004, 32'h3333_0003, 1, 1'b1);
`endif

        // Reset in the middle of a BUS cycle
        @(posedge clk); #1;
        read_to_mem = 1'b1;
        sel_to_mem  = 4'hF;
        adr_to_mem  = 32'h0000_6000;
        @(posedge clk); #1;
        chk("pre_rst_cyc", 32'(cyc_o), 32'(1));
        #1 rst = 1'b1;
        #1;
        model_rdata = 32'h0;
        chk("midrst_cyc", 32'(cyc_o), 32'(0));
        chk("midrst_stb", 32'(stb_o), 32'(0));
        chk("midrst_we", 32'(we_o), 32'(0));
        chk("midrst_sel", 32'(sel_o), 32'(0));
        chk("midrst_adr", adr_o, 32'h0);
        chk("midrst_dat", dat_o, 32'h0);
        chk("midrst_data", data_from_mem, 32'h0);
        chk("midrst_busy", 32'(mem_busy), 32'(0));
        chk("midrst_timeout", 32'(bus_timeout), 32'(0));
        @(posedge clk); #2;
        rst = 1'b0;
        read_to_mem = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(mem_busy), 32'(0));
        chk("post_rst_cyc", 32'(cyc_o), 32'(0));

        // Normal traffic after reset
        do_req(1'b1, 1'b0, 4'hF, 32'h0000_7002, 32'h0, 32'h0000_7000, 32'h4444_0004, 1, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drain", 32'(popped), 32'(pushed));
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_wishbone_bridge.md
Name: cpu_wishbone_bridge

Overview:
- Sits directly downstream of the CPU request unit, between it and the system Wishbone bus.
- Accepts the request unit's memory-side signals (read/write/sel/adr/data) and runs one Wishbone classic single-beat cycle per request.
- Holds mem_busy high until the cycle completes, then returns read data on data_from_mem.
- Converts the request unit's one-request-per-non-busy-cycle protocol into a registered bus handshake.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUS state without ack before abort (used only with the optional feature).
- ERR_DATA, 32'h0000_0000: value loaded into data_from_mem on a timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- read_to_mem  in  1  read request from request unit
- write_to_mem  in  1  write request from request unit
- sel_to_mem  in  4  byte lane select
- adr_to_mem  in  32  byte address
- data_to_mem  in  32  write data
- mem_busy  out  1  request in progress; request unit must hold its inputs
- data_from_mem  out  32  last completed read data (registered)
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  Wishbone write enable
- sel_o  out  4  Wishbone byte select
- adr_o  out  32  Wishbone address, word aligned
- dat_o  out  32  Wishbone write data
- ack_i  in  1  Wishbone acknowledge
- dat_i  in  32  Wishbone read data
- bus_timeout  out  1  one-cycle pulse on abort (tied 0 without the optional feature)

Behaviour:
- States: IDLE, BUS, DONE. Reset is asynchronous: state goes to IDLE and all registered outputs clear immediately.
- Reset values:
  - cyc_o, stb_o, we_o = 0; sel_o = 0; adr_o = 0; dat_o = 0.
  - data_from_mem = 0; bus_timeout = 0.
  - mem_busy = 0, since there is no request during reset.
- IDLE:
  - mem_busy = read_to_mem | write_to_mem (combinational), so the request unit stalls in the same cycle the request appears.
  - On a request, register we_o = write_to_mem, sel_o, adr_o = {adr_to_mem[31:2], 2'b00}, dat_o = data_to_mem, then go to BUS.
  - If read and write are both high, write wins.
  - No request: stay in IDLE with busy 0. The request unit's empty data phase passes in one cycle.
- BUS:
  - cyc_o = stb_o = 1; mem_busy = 1; all bus outputs held stable.
  - On ack_i: if the cycle is a read, data_from_mem <= dat_i; if a write, data_from_mem is unchanged. Then go to DONE.
- DONE:
  - cyc_o = stb_o = 0; mem_busy = 0 for exactly one cycle, during which the request unit samples data_from_mem and advances.
  - Next state is always IDLE.
- Minimum latency: request in cycle N with ack in cycle N+1 gives busy high in cycles N and N+1, busy low in N+2 (DONE), and the next request is accepted in N+3.
- ack_i in IDLE or DONE is ignored. dat_i is sampled only on ack_i in BUS.
- Request inputs that change while in BUS are ignored, because the registered copy is used.
- rst asserted mid-BUS aborts the cycle: cyc_o/stb_o drop asynchronously, and no data capture or timeout pulse occurs.

Optional Feature:
- Macro: CPU_WB_TIMEOUT_EN.
- Enabled:
  - An 8+-bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the bridge drops cyc/stb, loads data_from_mem = ERR_DATA (reads only), pulses bus_timeout for 1 cycle, and goes to DONE.
  - If ack_i and timeout coincide, ack wins and bus_timeout stays 0.
- Disabled: no counter; BUS waits indefinitely; bus_timeout is tied 0.

Test Plan:
- Reset check: assert rst mid-cycle -> all outputs 0 immediately; after release, IDLE with mem_busy=0.
- Read, zero wait: read_to_mem=1, adr=32'h0000_1006, sel=4'hF; ack with dat_i=32'hCAFE_F00D the cycle after -> adr_o=32'h0000_1004, we_o=0; data_from_mem=32'hCAFE_F00D and mem_busy=0 in DONE, 3-cycle request-to-DONE spacing.
- Write, 3 wait states: write_to_mem=1, sel=4'b0011, data=32'h1234_5678; ack delayed 3 cycles -> cyc/stb held 4 cycles, we_o=1, dat_o=32'h1234_5678; data_from_mem unchanged.
- No request: read=write=0 in IDLE -> mem_busy=0 and cyc_o=0 for the whole cycle; stray ack_i=1 leaves data_from_mem unchanged.
- Back-to-back fetch/data: alternating instruction read and data write driven by the request unit -> each completes in order, and busy drops exactly one cycle per transaction.
- With CPU_WB_TIMEOUT_EN and TIMEOUT_CYCLES=4, read with no ack -> abort after 4 BUS cycles; bus_timeout pulses once; data_from_mem=ERR_DATA; the next request proceeds normally.
